// File: rtl/sao_stat_pkg.sv
// Shared types and defaults for the SAO band-offset statistics accumulator.
package sao_stat_pkg;

  localparam int DEF_DIFF_CLIP_BIT = 4;
  localparam int DEF_N_PIX         = 4;
  localparam int DEF_N_BO_TYPE     = 5;
  localparam int DEF_SUM_W         = 18;
  localparam int DEF_CNT_W         = 13;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, READ} state_t;

  typedef logic        [DEF_N_BO_TYPE-1:0] band_t;
  typedef logic signed [DEF_DIFF_CLIP_BIT:0] diff_t;
  typedef logic signed [DEF_SUM_W-1:0]     bsum_t;
  typedef logic        [DEF_CNT_W-1:0]     bcnt_t;

  function automatic int num_band(input int n_bo_type);
    return 1 << n_bo_type;
  endfunction

endpackage

// File: rtl/sao_bo_merge.sv
// Combinational same-band merge: the first used pixel of each band becomes the
// leader and carries the summed diff and pixel count of all used pixels in its band.
module sao_bo_merge
  import sao_stat_pkg::*;
#(
  parameter int DIFF_CLIP_BIT = DEF_DIFF_CLIP_BIT,
  parameter int N_PIX         = DEF_N_PIX,
  parameter int N_BO_TYPE     = DEF_N_BO_TYPE,
  parameter int MW            = DIFF_CLIP_BIT + 1 + $clog2(N_PIX),
  parameter int CW            = $clog2(N_PIX + 1)
) (
  input  logic [N_PIX-1:0][DIFF_CLIP_BIT:0] n_diff,
  input  logic [N_PIX-1:0][N_BO_TYPE-1:0]   bo_cate,
  input  logic [N_PIX-1:0]                  b_use,
  output logic [N_PIX-1:0]                  lead,
  output logic [N_PIX-1:0][MW-1:0]          sum,
  output logic [N_PIX-1:0][CW-1:0]          cnt
);

  always_comb begin
    lead = '0;
    sum  = '0;
    cnt  = '0;
    for (int i = 0; i < N_PIX; i++) begin
      lead[i] = b_use[i];
      for (int j = 0; j < i; j++)
        if (b_use[j] && bo_cate[j] == bo_cate[i]) lead[i] = 1'b0;
      // Slots k>=i suffice: any earlier same-band pixel would have made i a non-leader.
      for (int k = i; k < N_PIX; k++)
        if (b_use[k] && bo_cate[k] == bo_cate[i]) begin
          sum[i] = sum[i] + MW'($signed(n_diff[k]));
          cnt[i] = cnt[i] + CW'(1);
        end
    end
  end

endmodule

// File: rtl/sao_bo_stat_acc.sv
// Band-offset statistics accumulator: merge -> per-band accumulate -> band readout.
// Define SAO_STAT_SAT_EN for saturating banks and the sticky sat_flag output.
module sao_bo_stat_acc
  import sao_stat_pkg::*;
#(
  parameter int DIFF_CLIP_BIT = DEF_DIFF_CLIP_BIT,
  parameter int N_PIX         = DEF_N_PIX,
  parameter int N_BO_TYPE     = DEF_N_BO_TYPE,
  parameter int SUM_W         = DEF_SUM_W,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [N_PIX-1:0][DIFF_CLIP_BIT:0] n_diff,
  input  logic [N_PIX-1:0][N_BO_TYPE-1:0]   bo_cate,
  input  logic [N_PIX-1:0]                  b_use,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_BO_TYPE-1:0]              out_band,
  output logic signed [SUM_W-1:0]           out_sum,
  output logic [CNT_W-1:0]                  out_cnt,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
`ifdef SAO_STAT_SAT_EN
  ,output logic                             sat_flag
`endif
);

  localparam int NUM_BAND = num_band(N_BO_TYPE);
  localparam int MW       = DIFF_CLIP_BIT + 1 + $clog2(N_PIX);
  localparam int CW       = $clog2(N_PIX + 1);

  state_t state, state_nxt;
  logic   acc, hs, last_hs, clr;
  logic [N_BO_TYPE-1:0] rd_band;

  logic [N_PIX-1:0]                m_lead, s1_lead;
  logic [N_PIX-1:0][MW-1:0]        m_sum, s1_sum;
  logic [N_PIX-1:0][CW-1:0]        m_cnt, s1_cnt;
  logic [N_PIX-1:0][N_BO_TYPE-1:0] s1_band;

  logic [SUM_W-1:0] bank_sum [NUM_BAND];
  logic [CNT_W-1:0] bank_cnt [NUM_BAND];
  logic [SUM_W-1:0] add_s    [NUM_BAND];
  logic [CNT_W-1:0] add_c    [NUM_BAND];
  logic [SUM_W-1:0] sum_nxt  [NUM_BAND];
  logic [CNT_W-1:0] cnt_nxt  [NUM_BAND];
`ifdef SAO_STAT_SAT_EN
  logic             sat_any;
  logic [SUM_W:0]   ext_s;
  logic [CNT_W:0]   ext_c;
`endif

  assign in_ready  = (state == ACC);
  assign out_valid = (state == READ);
  assign busy      = (state != IDLE);
  assign acc       = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign last_hs   = hs && (rd_band == N_BO_TYPE'(NUM_BAND - 1));
  assign clr       = (state == IDLE) && start;

  assign out_band  = out_valid ? rd_band : '0;
  assign out_sum   = out_valid ? bank_sum[rd_band] : '0;
  assign out_cnt   = out_valid ? bank_cnt[rd_band] : '0;
  assign out_last  = last_hs | (out_valid && rd_band == N_BO_TYPE'(NUM_BAND - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (acc && in_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = READ;
      READ:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_band <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last_hs;
      if (hs) rd_band <= rd_band + 1'b1;
    end
  end

  sao_bo_merge #(
    .DIFF_CLIP_BIT(DIFF_CLIP_BIT), .N_PIX(N_PIX), .N_BO_TYPE(N_BO_TYPE), .MW(MW), .CW(CW)
  ) u_merge (
    .n_diff (n_diff),
    .bo_cate(bo_cate),
    .b_use  (b_use),
    .lead   (m_lead),
    .sum    (m_sum),
    .cnt    (m_cnt)
  );

  // Stage 1: payload only moves on an accepted group; idle cycles carry no leaders.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_lead <= '0;
      s1_sum  <= '0;
      s1_cnt  <= '0;
      s1_band <= '0;
    end else if (acc) begin
      s1_lead <= m_lead;
      s1_sum  <= m_sum;
      s1_cnt  <= m_cnt;
      s1_band <= bo_cate;
    end else begin
      s1_lead <= '0;
    end
  end

  // Leaders of one group have distinct bands, so each bank sees at most one addend.
  always_comb begin
`ifdef SAO_STAT_SAT_EN
    sat_any = 1'b0;
    ext_s   = '0;
    ext_c   = '0;
`endif
    for (int b = 0; b < NUM_BAND; b++) begin
      add_s[b] = '0;
      add_c[b] = '0;
      for (int p = 0; p < N_PIX; p++)
        if (s1_lead[p] && s1_band[p] == N_BO_TYPE'(b)) begin
          add_s[b] = add_s[b] + SUM_W'($signed(s1_sum[p]));
          add_c[b] = add_c[b] + CNT_W'(s1_cnt[p]);
        end
`ifdef SAO_STAT_SAT_EN
      ext_s      = {bank_sum[b][SUM_W-1], bank_sum[b]} + {add_s[b][SUM_W-1], add_s[b]};
      ext_c      = {1'b0, bank_cnt[b]} + {1'b0, add_c[b]};
      sum_nxt[b] = ext_s[SUM_W-1:0];
      cnt_nxt[b] = ext_c[CNT_W-1:0];
      if (ext_s[SUM_W] != ext_s[SUM_W-1]) begin
        sum_nxt[b] = ext_s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        sat_any    = 1'b1;
      end
      if (ext_c[CNT_W]) begin
        cnt_nxt[b] = '1;
        sat_any    = 1'b1;
      end
`else
      sum_nxt[b] = bank_sum[b] + add_s[b];
      cnt_nxt[b] = bank_cnt[b] + add_c[b];
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BAND; b++) begin
      if (rst || clr) begin
        bank_sum[b] <= '0;
        bank_cnt[b] <= '0;
      end else begin
        bank_sum[b] <= sum_nxt[b];
        bank_cnt[b] <= cnt_nxt[b];
      end
    end
  end

`ifdef SAO_STAT_SAT_EN
  always_ff @(posedge clk) begin
    if (rst || clr)   sat_flag <= 1'b0;
    else if (sat_any) sat_flag <= 1'b1;
  end
`endif

endmodule
